alu_registers: RTL and testbench

Datapath core of the 8-bit accumulator-less CPU: a 16-entry × 8-bit register file with two synchronous write ports and two combinational read ports, plus a combinational ALU fed directly from the two read ports. The sequencer drives register indices, write strobes and the opcode fields, and uses the ALU result and carry to execute instructions. Registers 14/15 hold the 16-bit program counter, low byte in 14 and high byte in 15.

---
 rtl/alu_registers.sv | 158 +++++++++++++++
 tb/tb_alu_registers.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_registers.sv
// alu_registers: 16 x 8-bit register file (2 write ports, 2 read ports) feeding a combinational ALU.
// Latency: writes land on the rising clk edge; reads and ALU results are combinational (0 cycles).
// Backpressure: none; every write strobe is accepted on the edge it is presented.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> read ports forward same-cycle write data (port 1 has priority)
//   undefined -> read ports return stored contents only
//
// Ports:
//   clk, rst                     rising-edge clock, synchronous active-high reset (clears all registers)
//   write0/dstreg0/dstval0       write port 0 (enable, index, data)
//   write1/dstreg1/dstval1       write port 1 (enable, index, data); wins over port 0 on same index
//   argreg0/argreg1              read indices, also ALU operands A and B
//   argval0/argval1              read data
//   argval                       {argval1, argval0}, 16-bit address form (e.g. PC = {r15, r14})
//   alu_en/alu_fn                opcode bit 15 / bits 14:12
//   alu_y/alu_carry              ALU result and carry/flag
module alu_registers #(
    parameter int WIDTH_WORD = 8,
    parameter int WIDTH_SEG  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    write0,
    input  logic [WIDTH_SEG-1:0]    dstreg0,
    input  logic [WIDTH_WORD-1:0]   dstval0,
    input  logic                    write1,
    input  logic [WIDTH_SEG-1:0]    dstreg1,
    input  logic [WIDTH_WORD-1:0]   dstval1,
    input  logic [WIDTH_SEG-1:0]    argreg0,
    input  logic [WIDTH_SEG-1:0]    argreg1,
    output logic [WIDTH_WORD-1:0]   argval0,
    output logic [WIDTH_WORD-1:0]   argval1,
    output logic [2*WIDTH_WORD-1:0] argval,
    input  logic                    alu_en,
    input  logic [2:0]              alu_fn,
    output logic [WIDTH_WORD-1:0]   alu_y,
    output logic                    alu_carry
);

    localparam int NREG = 2 ** WIDTH_SEG;

    typedef enum logic [2:0] {
        FN_ADD = 3'b000,
        FN_SUB = 3'b001,
        FN_AND = 3'b010,
        FN_OR  = 3'b011,
        FN_NOT = 3'b100,
        FN_MV  = 3'b101,
        FN_LT  = 3'b110,
        FN_EQ  = 3'b111
    } alu_fn_t;

    logic [WIDTH_WORD-1:0] regs [NREG];

    // ------------------------------------------------------------------
    // Register file storage. Port 1 is assigned after port 0 so that it
    // takes precedence when both ports target the same register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (write0) begin
                regs[dstreg0] <= dstval0;
            end
            if (write1) begin
                regs[dstreg1] <= dstval1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    logic [WIDTH_WORD-1:0] rd0;
    logic [WIDTH_WORD-1:0] rd1;

`ifdef REGFILE_BYPASS_EN
    // Forwarding is suppressed during reset: the write is discarded at the
    // edge, so the read ports show stored contents just like the plain build.
    logic fwd0_p0;
    logic fwd0_p1;
    logic fwd1_p0;
    logic fwd1_p1;

    assign fwd0_p0 = !rst && write0 && (dstreg0 == argreg0);
    assign fwd0_p1 = !rst && write1 && (dstreg1 == argreg0);
    assign fwd1_p0 = !rst && write0 && (dstreg0 == argreg1);
    assign fwd1_p1 = !rst && write1 && (dstreg1 == argreg1);

    always_comb begin
        rd0 = regs[argreg0];
        if (fwd0_p1) begin
            rd0 = dstval1;
        end else if (fwd0_p0) begin
            rd0 = dstval0;
        end
    end

    always_comb begin
        rd1 = regs[argreg1];
        if (fwd1_p1) begin
            rd1 = dstval1;
        end else if (fwd1_p0) begin
            rd1 = dstval0;
        end
    end
`else
    assign rd0 = regs[argreg0];
    assign rd1 = regs[argreg1];
`endif

    assign argval0 = rd0;
    assign argval1 = rd1;
    assign argval  = {rd1, rd0};

    // ------------------------------------------------------------------
    // ALU. Sum and difference are computed one bit wider so the top bit
    // is the carry-out (ADD) or the borrow (SUB).
    // ------------------------------------------------------------------
    logic [WIDTH_WORD:0] sum_ext;
    logic [WIDTH_WORD:0] diff_ext;

    assign sum_ext  = {1'b0, rd0} + {1'b0, rd1};
    assign diff_ext = {1'b0, rd0} - {1'b0, rd1};

    always_comb begin
        alu_y     = '0;
        alu_carry = 1'b0;
        if (alu_en) begin
            case (alu_fn_t'(alu_fn))
                FN_ADD: begin
                    alu_y     = sum_ext[WIDTH_WORD-1:0];
                    alu_carry = sum_ext[WIDTH_WORD];
                end
                FN_SUB: begin
                    alu_y     = diff_ext[WIDTH_WORD-1:0];
                    alu_carry = diff_ext[WIDTH_WORD];
                end
                FN_AND: alu_y = rd0 & rd1;
                FN_OR:  alu_y = rd0 | rd1;
                FN_NOT: alu_y = ~rd0;
                FN_MV:  alu_y = rd0;
                // The borrow of A-B is exactly the unsigned A<B flag.
                FN_LT:  alu_carry = diff_ext[WIDTH_WORD];
                FN_EQ:  alu_carry = (rd0 == rd1);
                default: begin
                    alu_y     = '0;
                    alu_carry = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_registers.sv
module tb_alu_registers;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] AND = 3'b010;
    localparam logic [2:0] OR  = 3'b011;
    localparam logic [2:0] NOT = 3'b100;
    localparam logic [2:0] MV  = 3'b101;
    localparam logic [2:0] LT  = 3'b110;
    localparam logic [2:0] EQ  = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic        write0;
    logic [3:0]  dstreg0;
    logic [7:0]  dstval0;
    logic        write1;
    logic [3:0]  dstreg1;
    logic [7:0]  dstval1;
    logic [3:0]  argreg0;
    logic [3:0]  argreg1;
    logic [7:0]  argval0;
    logic [7:0]  argval1;
    logic [15:0] argval;
    logic        alu_en;
    logic [2:0]  alu_fn;
    logic [7:0]  alu_y;
    logic        alu_carry;

    always #5 clk = ~clk;

    alu_registers #(.WIDTH_WORD(8), .WIDTH_SEG(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .write0    (write0),
        .dstreg0   (dstreg0),
        .dstval0   (dstval0),
        .write1    (write1),
        .dstreg1   (dstreg1),
        .dstval1   (dstval1),
        .argreg0   (argreg0),
        .argreg1   (argreg1),
        .argval0   (argval0),
        .argval1   (argval1),
        .argval    (argval),
        .alu_en    (alu_en),
        .alu_fn    (alu_fn),
        .alu_y     (alu_y),
        .alu_carry (alu_carry)
    );

    typedef struct packed {
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] y;
        logic       c;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    logic  chk_vld = 1'b0;
    int    n_pass  = 0;
    int    n_total = 0;

    task automatic check8(input string nm, input string fld, input logic [15:0] act, input logic [15:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, req);
        end
    endtask

    // Monitor: on the falling edge of every cycle the stimulus marks as
    // checked, pop the oldest expectation and compare all outputs.
    always @(negedge clk) begin
        if (chk_vld) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL monitor: output presented, got no expectation, expected queued entry");
            end else begin
                exp_t  e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check8(nm, "argval0",   {8'h00, argval0},   {8'h00, e.a0});
                check8(nm, "argval1",   {8'h00, argval1},   {8'h00, e.a1});
                check8(nm, "argval",    argval,             {e.a1, e.a0});
                check8(nm, "alu_y",     {8'h00, alu_y},     {8'h00, e.y});
                check8(nm, "alu_carry", {15'h0, alu_carry}, {15'h0, e.c});
            end
        end
    end

    // Drive one cycle of stimulus; when chk is set the expected outputs for
    // this cycle (observed before the edge commits any write) are queued.
    task automatic cyc(input string nm, input logic chk, input logic r,
                       input logic w0, input logic [3:0] dr0, input logic [7:0] dv0,
                       input logic w1, input logic [3:0] dr1, input logic [7:0] dv1,
                       input logic [3:0] ar0, input logic [3:0] ar1,
                       input logic en, input logic [2:0] fn,
                       input logic [7:0] e0, input logic [7:0] e1,
                       input logic [7:0] ey, input logic ec);
        exp_t e;
        rst = r;
        write0 = w0; dstreg0 = dr0; dstval0 = dv0;
        write1 = w1; dstreg1 = dr1; dstval1 = dv1;
        argreg0 = ar0; argreg1 = ar1;
        alu_en = en; alu_fn = fn;
        if (chk) begin
            e.a0 = e0; e.a1 = e1; e.y = ey; e.c = ec;
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        chk_vld = chk;
        @(posedge clk);
        #1;
        chk_vld = 1'b0;
    endtask

    initial begin
        rst = 1'b1; write0 = 1'b0; write1 = 1'b0;
        dstreg0 = '0; dstval0 = '0; dstreg1 = '0; dstval1 = '0;
        argreg0 = '0; argreg1 = '0; alu_en = 1'b0; alu_fn = '0;
        @(posedge clk);
        #1;
        //        name          chk rst  w0 dr0 dv0     w1 dr1 dv1     ar0 ar1 en fn    a0     a1     y      c
        cyc("init_rst",         0, 1,   0, 0,  8'h00,  0, 0,  8'h00,  0,  0,  0, ADD, 8'h00, 8'h00, 8'h00, 0);
        cyc("rst_state",        1, 0,   0, 0,  8'h00,  0, 0,  8'h00,  0,  15, 0, ADD, 8'h00, 8'h00, 8'h00, 0);
        cyc("rst_eq_zero",      1, 0,   0, 0,  8'h00,  0, 0,  8'h00,  14, 15, 1, EQ,  8'h00, 8'h00, 8'h00, 1);
        cyc("arb_write",        1, 0,   1, 5,  8'hAA,  1, 9,  8'h55,  5,  9,  1, ADD, 8'h00, 8'h00, 8'h00, 0);
        // Reset asserted with a write pending: reset must win.
        cyc("rst_with_write",   1, 1,   1, 5,  8'h11,  0, 0,  8'h00,  5,  9,  1, OR,  8'hAA, 8'h55, 8'hFF, 0);
        cyc("after_rst_5_9",    1, 0,   0, 0,  8'h00,  0, 0,  8'h00,  5,  9,  0, ADD, 8'h00, 8'h00, 8'h00, 0);
        cyc("dual_write",       1, 0,   1, 1,  8'd8,   1, 2,  8'd100, 1,  2,  0, ADD, 8'h00, 8'h00, 8'h00, 0);
        cyc("dual_read_add",    1, 0,   0, 0,  8'h00,  0, 0,  8'h00,  1,  2,  1, ADD, 8'd8,  8'd100, 8'd108, 0);
        cyc("same_dst_write",   1, 0,   1, 3,  8'd5,   1, 3,  8'd9,   3,  3,  0, ADD, 8'h00, 8'h00, 8'h00, 0);
        cyc("same_dst_p1_wins", 1, 0,   0, 0,  8'h00,  0, 0,  8'h00,  3,  3,  1, EQ,  8'd9,  8'd9,  8'h00, 1);
        cyc("pc_write",         1, 0,   1, 14, 8'h12,  1, 15, 8'h34,  14, 15, 0, ADD, 8'h00, 8'h00, 8'h00, 0);
        cyc("pc_read",          1, 0,   0, 0,  8'h00,  0, 0,  8'h00,  14, 15, 0, ADD, 8'h12, 8'h34, 8'h00, 0);
        cyc("load_200_100",     1, 0,   1, 6,  8'd200, 1, 7,  8'd100, 6,  7,  0, ADD, 8'h00, 8'h00, 8'h00, 0);
        cyc("add_200_100",      1, 0,   0, 0,  8'h00,  0, 0,  8'h00,  6,  7,  1, ADD, 8'd200, 8'd100, 8'd44, 1);
        cyc("sub_200_100",      1, 0,   0, 0,  8'h00,  0, 0,  8'h00,  6,  7,  1, SUB, 8'd200, 8'd100, 8'd100, 0);
        cyc("lt_200_100",       1, 0,   0, 0,  8'h00,  0, 0,  8'h00,  6,  7,  1, LT,  8'd200, 8'd100, 8'h00, 0);
        cyc("load_3_5",         1, 0,   1, 8,  8'd3,   1, 10, 8'd5,   6,  7,  0, ADD, 8'd200, 8'd100, 8'h00, 0);
        cyc("sub_3_5",          1, 0,   0, 0,  8'h00,  0, 0,  8'h00,  8,  10, 1, SUB, 8'd3,  8'd5,  8'd254, 1);
        cyc("add_3_5",          1, 0,   0, 0,  8'h00,  0, 0,  8'h00,  8,  10, 1, ADD, 8'd3,  8'd5,  8'd8,   0);
        cyc("load_f0_3c",       1, 0,   1, 11, 8'hF0,  1, 12, 8'h3C,  8,  10, 1, LT,  8'd3,  8'd5,  8'h00, 1);
        cyc("and_f0_3c",        1, 0,   0, 0,  8'h00,  0, 0,  8'h00,  11, 12, 1, AND, 8'hF0, 8'h3C, 8'h30, 0);
        cyc("or_f0_3c",         1, 0,   0, 0,  8'h00,  0, 0,  8'h00,  11, 12, 1, OR,  8'hF0, 8'h3C, 8'hFC, 0);
        cyc("not_f0",           1, 0,   0, 0,  8'h00,  0, 0,  8'h00,  11, 12, 1, NOT, 8'hF0, 8'h3C, 8'h0F, 0);
        cyc("mv_f0",            1, 0,   0, 0,  8'h00,  0, 0,  8'h00,  11, 12, 1, MV,  8'hF0, 8'h3C, 8'hF0, 0);
        cyc("lt_f0_3c",         1, 0,   0, 0,  8'h00,  0, 0,  8'h00,  11, 12, 1, LT,  8'hF0, 8'h3C, 8'h00, 0);
        cyc("eq_f0_3c",         1, 0,   0, 0,  8'h00,  0, 0,  8'h00,  11, 12, 1, EQ,  8'hF0, 8'h3C, 8'h00, 0);
        cyc("lt_3_100",         1, 0,   0, 0,  8'h00,  0, 0,  8'h00,  8,  7,  1, LT,  8'd3,  8'd100, 8'h00, 1);
        cyc("lt_100_100",       1, 0,   0, 0,  8'h00,  0, 0,  8'h00,  7,  7,  1, LT,  8'd100, 8'd100, 8'h00, 0);
        cyc("eq_100_100",       1, 0,   0, 0,  8'h00,  0, 0,  8'h00,  7,  7,  1, EQ,  8'd100, 8'd100, 8'h00, 1);
        cyc("alu_disabled",     1, 0,   0, 0,  8'h00,  0, 0,  8'h00,  6,  7,  0, ADD, 8'd200, 8'd100, 8'h00, 0);
`ifdef REGFILE_BYPASS_EN
        cyc("bypass_p0",        1, 0,   1, 4,  8'd7,   0, 0,  8'h00,  4,  4,  1, MV,  8'd7,  8'd7,  8'd7,  0);
        cyc("bypass_p1_prio",   1, 0,   1, 4,  8'h21,  1, 4,  8'h42,  4,  12, 1, ADD, 8'h42, 8'h3C, 8'h7E, 0);
`else
        cyc("bypass_p0",        1, 0,   1, 4,  8'd7,   0, 0,  8'h00,  4,  4,  1, MV,  8'h00, 8'h00, 8'h00, 0);
        cyc("bypass_p1_prio",   1, 0,   1, 4,  8'h21,  1, 4,  8'h42,  4,  12, 1, ADD, 8'd7,  8'h3C, 8'h43, 0);
`endif
        cyc("reg4_readback",    1, 0,   0, 0,  8'h00,  0, 0,  8'h00,  4,  4,  1, MV,  8'h42, 8'h42, 8'h42, 0);
        // Mid-sequence reset: stored values still visible this cycle, gone next.
        cyc("midseq_rst",       1, 1,   1, 14, 8'hFF,  0, 0,  8'h00,  14, 15, 1, ADD, 8'h12, 8'h34, 8'h46, 0);
        cyc("after_mid_pc",     1, 0,   0, 0,  8'h00,  0, 0,  8'h00,  14, 15, 1, ADD, 8'h00, 8'h00, 8'h00, 0);
        cyc("after_mid_7_11",   1, 0,   0, 0,  8'h00,  0, 0,  8'h00,  7,  11, 1, EQ,  8'h00, 8'h00, 8'h00, 1);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit, expected completion");
        $fatal(1, "timeout");
    end

endmodule
